// File: rtl/rank_filter.sv
`default_nettype none
// ============================================================================
// Module      : rank_filter
// Description : Rank-order filter. Collects a block of W samples, sorts them
//               in place with an odd-even transposition network (one phase
//               per clock) and outputs the sample at a run-time selectable
//               rank (0 = min, W/2 = median, W-1 = max).
// Revision    : 1.0 - initial release
// ============================================================================
module rank_filter #(
    parameter int N      = 8,
    parameter int W      = 9,
    parameter bit SIGNED = 1'b0,
    localparam int RW    = $clog2(W)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [N-1:0]  DI,
    input  logic          DSI,
    input  logic [RW-1:0] RSEL,
    output logic [N-1:0]  DO,
    output logic          DSO,
    output logic          READY,
    output logic          OVF
);

    // Highest sample index; also the last sort phase and the rank clamp value.
    localparam logic [RW-1:0] c_last = RW'(W - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   cnt_q,   cnt_d;
    logic [RW-1:0]   phase_q, phase_d;
    logic [RW-1:0]   rsel_q,  rsel_d;
    logic [N-1:0]    smp_q [W];
    logic [N-1:0]    smp_d [W];
    logic [N-1:0]    smp_sorted [W];
    logic [N-1:0]    do_q,    do_d;
    logic            dso_q,   dso_d;
    logic            ovf_q,   ovf_d;

    // w_gt[i] is set when element i is greater than element i+1 and must swap.
    logic [W-2:0]    w_gt;

    for (genvar gi = 0; gi < W - 1; gi++) begin : g_cmp
        if (SIGNED) begin : g_signed
            assign w_gt[gi] = $signed(smp_q[gi]) > $signed(smp_q[gi+1]);
        end else begin : g_unsigned
            assign w_gt[gi] = smp_q[gi] > smp_q[gi+1];
        end
    end

    // One transposition phase: even phases pair (0,1),(2,3)..; odd phases
    // pair (1,2),(3,4)... Pairs within a phase never overlap, so every swap
    // reads only current-state values.
    always_comb begin
        smp_sorted = smp_q;
        for (int i = 0; i < W - 1; i++) begin
            if ((i[0] == phase_q[0]) && w_gt[i]) begin
                smp_sorted[i]     = smp_q[i+1];
                smp_sorted[i+1]   = smp_q[i];
            end
        end
    end

    // Next-state logic for the load / sort / output sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        rsel_d  = rsel_q;
        smp_d   = smp_q;
        do_d    = do_q;
        dso_d   = 1'b0;
        ovf_d   = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (DSI) begin
                    smp_d[cnt_q] = DI;
                    if (cnt_q == c_last) begin
                        cnt_d   = '0;
                        phase_d = '0;
                        rsel_d  = (RSEL > c_last) ? c_last : RSEL;
                        state_d = ST_SORT;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            ST_SORT: begin
                smp_d   = smp_sorted;
                phase_d = phase_q + 1'b1;
                if (phase_q == c_last) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                do_d    = smp_q[rsel_q];
                dso_d   = 1'b1;
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Samples offered while busy are discarded and flagged for one cycle.
        if (DSI && (state_q != ST_LOAD)) begin
            ovf_d = 1'b1;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            phase_q <= '0;
            rsel_q  <= '0;
            do_q    <= '0;
            dso_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            rsel_q  <= rsel_d;
            do_q    <= do_d;
            dso_q   <= dso_d;
            ovf_q   <= ovf_d;
        end
    end

    // Sample buffer; contents after reset are irrelevant since a block is
    // always fully reloaded before it is sorted.
    always_ff @(posedge CLK) begin
        smp_q <= smp_d;
    end

    assign DO    = do_q;
    assign DSO   = dso_q;
    assign OVF   = ovf_q;
    assign READY = (state_q == ST_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_rank_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rank_filter
// Description : Scoreboard bench for rank_filter (W=9, N=8, unsigned).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rank_filter;

    localparam int N  = 8;
    localparam int W  = 9;
    localparam bit SG = 1'b0;
    localparam int RW = $clog2(W);

    typedef struct {
        logic [N-1:0] d;
        int           c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  di;
    logic          dsi;
    logic [RW-1:0] rsel;
    logic [N-1:0]  do_o;
    logic          dso_o;
    logic          ready_o;
    logic          ovf_o;

    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    exp_t          sb[$];
    exp_t          e;
    bit            mon_en = 1'b0;
    logic [N-1:0]  last_exp = '0;

    rank_filter #(.N(N), .W(W), .SIGNED(SG)) dut (
        .CLK   (clk),
        .RST   (rst),
        .DI    (di),
        .DSI   (dsi),
        .RSEL  (rsel),
        .DO    (do_o),
        .DSO   (dso_o),
        .READY (ready_o),
        .OVF   (ovf_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic bit lt(input logic [N-1:0] a, input logic [N-1:0] b);
        if (SG) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    // Reference: value v[j] has rank r when (#less) <= r < (#less + #equal).
    function automatic logic [N-1:0] ref_rank(input logic [N-1:0] v[W], input int r);
        int rr;
        int nl;
        int ne;
        rr = (r > W - 1) ? W - 1 : r;
        for (int j = 0; j < W; j++) begin
            nl = 0;
            ne = 0;
            for (int k = 0; k < W; k++) begin
                if (lt(v[k], v[j])) nl++;
                else if (v[k] == v[j]) ne++;
            end
            if (nl <= rr && rr < nl + ne) return v[j];
        end
        return '0;
    endfunction

    // Monitor: pops an expected result on every DSO pulse, otherwise DO must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (dso_o === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("dso_unexpected", 32'(dso_o), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("do_result", 32'(do_o), 32'(e.d));
                    chk("latency", cyc, e.c);
                    last_exp = e.d;
                end
            end else begin
                chk("do_hold", 32'(do_o), 32'(last_exp));
            end
        end
    end

    task automatic wait_ready();
        for (int k = 0; k < 100; k++) begin
            if (ready_o === 1'b1) break;
            @(posedge clk); #1;
        end
        chk("ready_wait", 32'(ready_o), 32'd1);
    endtask

    task automatic send_block(input logic [N-1:0] v[W], input logic [RW-1:0] rs,
                              input int gap, input logic [N-1:0] exp, input bit push);
        exp_t x;
        wait_ready();
        for (int i = 0; i < W; i++) begin
            @(posedge clk); #1;
            di   = v[i];
            dsi  = 1'b1;
            rsel = (i == W - 1) ? rs : (rs ^ {RW{1'b1}});
            if (i == W - 1 && push) begin
                x.d = exp;
                x.c = cyc + 1 + W + 1;
                sb.push_back(x);
            end
            if (i != W - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    dsi = 1'b0;
                    di  = 8'hEE;
                end
            end
        end
        @(posedge clk); #1;
        dsi  = 1'b0;
        rsel = RW'($urandom_range(0, 15));
    endtask

    initial begin
        logic [N-1:0]  b1 [W];
        logic [N-1:0]  b2 [W];
        logic [N-1:0]  b3 [W];
        logic [N-1:0]  rb [W];
        logic [RW-1:0] rs;

        b1 = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        b2 = '{8'd3, 8'd200, 8'd17, 8'd99, 8'd0, 8'd255, 8'd42, 8'd42, 8'd7};
        b3 = '{8'd5, 8'd5, 8'd9, 8'd5, 8'd1, 8'd5, 8'd5, 8'd9, 8'd5};

        rst  = 1'b1;
        dsi  = 1'b0;
        di   = '0;
        rsel = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_do",    32'(do_o),    32'd0);
        chk("rst_dso",   32'(dso_o),   32'd0);
        chk("rst_ovf",   32'(ovf_o),   32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        mon_en = 1'b1;

        // Directed blocks with hand-computed results
        send_block(b1, 4'd4,  0, 8'd5,   1'b1);
        send_block(b2, 4'd0,  0, 8'd0,   1'b1);
        send_block(b2, 4'd8,  0, 8'd255, 1'b1);
        send_block(b2, 4'd4,  0, 8'd42,  1'b1);
        send_block(b2, 4'd15, 0, 8'd255, 1'b1);
        send_block(b3, 4'd6,  0, 8'd5,   1'b1);
        send_block(b3, 4'd7,  0, 8'd9,   1'b1);
        send_block(b1, 4'd4,  1, 8'd5,   1'b1);
        send_block(b2, 4'd2,  1, 8'd7,   1'b1);

        // Sample offered during SORT is dropped and flagged
        send_block(b2, 4'd6, 0, 8'd99, 1'b1);
        chk("busy_ready", 32'(ready_o), 32'd0);
        dsi = 1'b1;
        di  = 8'h00;
        @(posedge clk); #1;
        dsi = 1'b0;
        chk("ovf_pulse", 32'(ovf_o), 32'd1);
        @(posedge clk); #1;
        chk("ovf_clear", 32'(ovf_o), 32'd0);
        send_block(b1, 4'd0, 0, 8'd1, 1'b1);

        // Reset in the third SORT cycle abandons the block
        send_block(b2, 4'd8, 0, 8'd0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_exp = '0;
        chk("mid_rst_ready", 32'(ready_o), 32'd1);
        chk("mid_rst_do",    32'(do_o),    32'd0);
        repeat (15) @(posedge clk);
        #1;
        send_block(b1, 4'd4, 0, 8'd5, 1'b1);

        // Random blocks against the reference model
        for (int b = 0; b < 300; b++) begin
            for (int k = 0; k < W; k++) begin
                rb[k] = (b % 3 == 0) ? N'($urandom_range(0, 3)) : N'($urandom);
            end
            rs = RW'($urandom_range(0, 15));
            send_block(rb, rs, int'($urandom_range(0, 1)), ref_rank(rb, int'(rs)), 1'b1);
        end

        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        chk("drain", sb.size(), 32'd0);
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
